// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage controller: one-hot state encodings,
// memory mode codes and the default data memory size.
package mem_access_unit_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_READ  = 5'b00010,
    S_RDATA = 5'b00100,
    S_WRITE = 5'b01000,
    S_RESP  = 5'b10000
  } state_t;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;

  localparam int MEM_BYTES_DEFAULT = 2048;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data extension: byte loads take [7:0] and sign- or zero-extend it,
// word loads pass through unchanged.
module mem_access_unit_load_extend #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] raw,
  input  logic              byte_acc,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = raw;
    if (byte_acc) begin
      if (sign_ext) ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
      else          ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load/store per handshake, drives the data memory
// strobes and returns one response per request. Access fault checks under MAU_FAULT_EN.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// READ    | mem_rd strobe, memory samples address at the end of the cycle
// RDATA   | registered memory data is extended into resp_data
// WRITE   | mem_wn strobe, memory writes on the mid-cycle negedge
// RESP    | response held stable until resp_ready
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int TAG_W  = 3
`ifdef MAU_FAULT_EN
  , parameter int MEM_BYTES = MEM_BYTES_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_is_load,
  output logic              resp_fault,
  output logic              mem_rd,
  output logic              mem_wn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_mode,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              byte_q;
  logic              signed_q;
  logic              write_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] ext_data;
  logic              fault_now;

`ifdef MAU_FAULT_EN
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  logic [ADDR_W:0] span_end;

  // one extra bit so the last byte of a word at the top of the address space cannot wrap
  always_comb begin
    span_end  = {1'b0, req_addr} + {{ADDR_W{1'b0}}, ~req_byte};
    fault_now = (!req_byte && req_addr[0]) || (span_end >= MEM_LIMIT);
  end
`else
  always_comb fault_now = 1'b0;
`endif

  mem_access_unit_load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw      (mem_read_data),
    .byte_acc (byte_q),
    .sign_ext (signed_q),
    .ext      (ext_data)
  );

  assign mem_address    = addr_q;
  assign mem_mode       = byte_q ? MODE_BYTE : MODE_WORD;
  assign mem_write_data = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      mem_rd       <= 1'b0;
      mem_wn       <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_tag     <= '0;
      resp_is_load <= 1'b0;
      resp_fault   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      tag_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            byte_q    <= req_byte;
            signed_q  <= req_signed;
            write_q   <= req_write;
            tag_q     <= req_tag;
            req_ready <= 1'b0;
            if (fault_now) begin
              state        <= S_RESP;
              resp_valid   <= 1'b1;
              resp_data    <= '0;
              resp_tag     <= req_tag;
              resp_is_load <= !req_write;
              resp_fault   <= 1'b1;
            end else if (req_write) begin
              state  <= S_WRITE;
              mem_wn <= 1'b1;
            end else begin
              state  <= S_READ;
              mem_rd <= 1'b1;
            end
          end
        end
        S_READ: begin
          state  <= S_RDATA;
          mem_rd <= 1'b0;
        end
        S_RDATA: begin
          state        <= S_RESP;
          resp_valid   <= 1'b1;
          resp_data    <= ext_data;
          resp_tag     <= tag_q;
          resp_is_load <= !write_q;
          resp_fault   <= 1'b0;
        end
        S_WRITE: begin
          state        <= S_RESP;
          mem_wn       <= 1'b0;
          resp_valid   <= 1'b1;
          resp_data    <= '0;
          resp_tag     <= tag_q;
          resp_is_load <= !write_q;
          resp_fault   <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          mem_rd     <= 1'b0;
          mem_wn     <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory, cycle-level reference model of the
// request/response timeline, directed literal checks and a randomized phase.
module tb_mem_access_unit;

  localparam int MEMB = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [2:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_data;
  logic [2:0]  resp_tag;
  logic        resp_is_load;
  logic        resp_fault;
  logic        mem_rd;
  logic        mem_wn;
  logic [15:0] mem_address;
  logic [1:0]  mem_mode;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_is_load(resp_is_load), .resp_fault(resp_fault),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address), .mem_mode(mem_mode),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [7:0] phys [0:65535];
  logic [7:0] refm [0:65535];

  // memory: registered read on posedge (byte read leaves junk in [15:8]), write on negedge
  always @(posedge clk) begin
    if (mem_rd) begin
      if (mem_mode == 2'b01) mem_read_data <= {8'($urandom), phys[mem_address]};
      else                   mem_read_data <= {phys[mem_address], phys[16'(mem_address + 16'd1)]};
    end
  end

  int wn_count = 0;
  int rd_count = 0;
  always @(negedge clk) begin
    if (mem_wn) begin
      wn_count++;
      if (mem_mode == 2'b01) phys[mem_address] = mem_write_data[7:0];
      else begin
        phys[mem_address] = mem_write_data[15:8];
        phys[16'(mem_address + 16'd1)] = mem_write_data[7:0];
      end
    end
    if (mem_rd) rd_count++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fault_of(input bit b, input logic [15:0] a);
`ifdef MAU_FAULT_EN
    return (!b && a[0]) || ((int'(a) + (b ? 0 : 1)) >= MEMB);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] ref_load(input bit b, input bit s, input logic [15:0] a);
    logic [7:0] v;
    if (b) begin
      v = refm[a];
      return s ? {{8{v[7]}}, v} : {8'h00, v};
    end
    return {refm[a], refm[16'(a + 16'd1)]};
  endfunction

  // reference model: where the current request is on its timeline
  bit          m_busy = 0, m_inresp = 0, m_load = 0, m_fault = 0, m_byte = 0;
  int          m_k = 0, m_lat = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_exp = '0;
  logic [2:0]  m_tag = '0;
  int          resp_count = 0;
  logic [15:0] last_data = '0;
  logic [2:0]  last_tag = '0;
  logic        last_load = 0, last_fault = 0;

  initial begin
    bit erd, ewn;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wn", mem_wn, 0);
      end else begin
        erd = m_busy && !m_inresp && m_load && (m_k == 1);
        ewn = m_busy && !m_inresp && !m_load && (m_k == 1);
        chk("req_ready", req_ready, !m_busy);
        chk("resp_valid", resp_valid, m_inresp);
        chk("mem_rd", mem_rd, erd);
        chk("mem_wn", mem_wn, ewn);
        if (erd || ewn) begin
          chk("mem_address", mem_address, m_addr);
          chk("mem_mode", mem_mode, m_byte ? 2'b01 : 2'b00);
        end
        if (ewn) chk("mem_write_data", mem_write_data, m_wdata);
        if (m_inresp) begin
          chk("resp_data", resp_data, m_exp);
          chk("resp_tag", resp_tag, m_tag);
          chk("resp_is_load", resp_is_load, m_load);
          chk("resp_fault", resp_fault, m_fault);
          last_data = resp_data; last_tag = resp_tag;
          last_load = resp_is_load; last_fault = resp_fault;
        end
      end
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_inresp = 0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_busy  = 1;
          m_load  = !req_write;
          m_byte  = req_byte;
          m_addr  = req_addr;
          m_wdata = req_wdata;
          m_tag   = req_tag;
          m_fault = fault_of(req_byte, req_addr);
          m_lat   = m_fault ? 1 : (m_load ? 3 : 2);
          m_k     = 1;
          m_inresp = (m_lat == 1);
          m_exp   = (m_fault || !m_load) ? 16'h0 : ref_load(req_byte, req_signed, req_addr);
          if (!m_fault && !m_load) begin
            if (req_byte) refm[req_addr] = req_wdata[7:0];
            else begin
              refm[req_addr] = req_wdata[15:8];
              refm[16'(req_addr + 16'd1)] = req_wdata[7:0];
            end
          end
        end
      end else if (!m_inresp) begin
        m_k++;
        if (m_k == m_lat) m_inresp = 1;
      end else if (resp_ready) begin
        m_busy = 0; m_inresp = 0;
        resp_count++;
      end
    end
  end

  bit rr_force = 1, rr_val = 1;
  initial forever begin
    @(posedge clk); #2;
    resp_ready = rr_force ? rr_val : ($urandom_range(0, 99) < 70);
  end

  // callers sit at posedge+2; returns at posedge+2 after the accepting edge
  task automatic send_req(input bit w, input bit b, input bit s, input logic [15:0] a,
                          input logic [15:0] d, input logic [2:0] t);
    bit ok = 0;
    req_valid = 1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = d; req_tag = t;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk); #2;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready never seen for addr %h", a);
    end
    req_valid = 0; req_write = 1'($urandom); req_addr = 16'($urandom);
    req_wdata = 16'($urandom); req_tag = 3'($urandom);
  endtask

  task automatic wait_count(input int target);
    for (int i = 0; i < 80 && resp_count < target; i++) begin
      @(posedge clk); #2;
    end
    if (resp_count < target) begin
      checks++; errors++;
      $display("FAIL resp_timeout: count %0d expected %0d", resp_count, target);
    end
  endtask

  task automatic do_req(input bit w, input bit b, input bit s, input logic [15:0] a,
                        input logic [15:0] d, input logic [2:0] t);
    int target = resp_count + 1;
    send_req(w, b, s, a, d, t);
    wait_count(target);
  endtask

  initial begin
    int c0, wn0, rd0;
    bit ok;
    logic [15:0] a;
    bit b;
    for (int i = 0; i < 65536; i++) begin
      phys[i] = 8'($urandom);
      refm[i] = phys[i];
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;

    // word store then word load
    wn0 = wn_count;
    do_req(1, 0, 0, 16'h0010, 16'hBEEF, 3'd0);
    chk("st_wn_pulses", wn_count - wn0, 1);
    chk("st_is_load", last_load, 0);
    rd0 = rd_count;
    do_req(0, 0, 0, 16'h0010, 16'h0000, 3'd5);
    chk("ld_word_data", last_data, 16'hBEEF);
    chk("ld_word_tag", last_tag, 3'd5);
    chk("ld_word_is_load", last_load, 1);
    chk("ld_rd_pulses", rd_count - rd0, 1);

    // byte store then signed/unsigned byte loads
    do_req(1, 1, 0, 16'h0021, 16'h1280, 3'd0);
    do_req(0, 1, 1, 16'h0021, 16'h0000, 3'd2);
    chk("ld_byte_signed", last_data, 16'hFF80);
    do_req(0, 1, 0, 16'h0021, 16'h0000, 3'd3);
    chk("ld_byte_unsigned", last_data, 16'h0080);

    // back-pressure with a second request waiting
    c0 = resp_count;
    rr_val = 0;
    send_req(1, 0, 0, 16'h0040, 16'h1234, 3'd1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (m_inresp) ok = 1;
      else begin @(posedge clk); #2; end
    end
    chk("bp_reached_resp", ok, 1);
    req_valid = 1; req_write = 0; req_byte = 0; req_signed = 0;
    req_addr = 16'h0040; req_tag = 3'd6;
    repeat (4) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_tag", resp_tag, 3'd1);
      @(posedge clk); #2;
    end
    rr_val = 1;
    send_req(0, 0, 0, 16'h0040, 16'h0000, 3'd6);
    wait_count(c0 + 2);
    chk("bp_second_data", last_data, 16'h1234);
    chk("bp_second_tag", last_tag, 3'd6);

    // async reset while in READ discards the load
    c0 = resp_count;
    send_req(0, 0, 0, 16'h0010, 16'h0000, 3'd4);
    #1 rst_n = 0;
    #1;
    chk("rstrd_req_ready", req_ready, 1);
    chk("rstrd_mem_rd", mem_rd, 0);
    chk("rstrd_resp_valid", resp_valid, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #2;
    chk("rstrd_no_resp", resp_count, c0);
    do_req(0, 0, 0, 16'h0010, 16'h0000, 3'd7);
    chk("rstrd_reload_data", last_data, 16'hBEEF);
    chk("rstrd_reload_tag", last_tag, 3'd7);

    // fault candidates
    rd0 = rd_count;
    do_req(0, 0, 0, 16'h0011, 16'h0000, 3'd1);
`ifdef MAU_FAULT_EN
    chk("flt_misalign_fault", last_fault, 1);
    chk("flt_misalign_data", last_data, 16'h0000);
    chk("flt_misalign_is_load", last_load, 1);
    chk("flt_misalign_no_rd", rd_count - rd0, 0);
`else
    chk("nof_misalign_fault", last_fault, 0);
    chk("nof_misalign_rd", rd_count - rd0, 1);
`endif
    rd0 = rd_count;
    do_req(0, 1, 0, 16'h0800, 16'h0000, 3'd2);
`ifdef MAU_FAULT_EN
    chk("flt_range_fault", last_fault, 1);
    chk("flt_range_data", last_data, 16'h0000);
    chk("flt_range_no_rd", rd_count - rd0, 0);
`else
    chk("nof_range_fault", last_fault, 0);
    chk("nof_range_rd", rd_count - rd0, 1);
`endif

    // randomized traffic with random response back-pressure
    rr_force = 0;
    for (int n = 0; n < 300; n++) begin
      b = 1'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 16'($urandom_range(0, 255));
        6, 7, 8:          a = 16'($urandom_range(0, 2047));
        default:          a = $urandom_range(0, 1) ? 16'($urandom_range(2040, 2056)) : 16'($urandom);
      endcase
      if (!b && $urandom_range(0, 4) != 0) a[0] = 1'b0;
      send_req(1'($urandom), b, 1'($urandom), a, 16'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    rr_force = 1; rr_val = 1;
    for (int i = 0; i < 40 && m_busy; i++) begin @(posedge clk); #2; end
    chk("drain_idle", m_busy, 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
